// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//
// Two-requester front end for a single shared combinational shifter. It accepts
// one request at a time, drives the registered operands to the external shifter
// for one cycle, captures the result and holds it until the owning requester
// takes it. Transactions never overlap, so the minimum issue interval is three
// cycles (IDLE -> SHIFT -> RESP).
//
// Parameters
//   RR_EN      1: round-robin on contention, 0: requester 0 always wins.
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester request strobe (bit i = requester i)
//   req_ready  per-requester accept, only ever set in IDLE for the winner
//   req0_*     requester 0 operand: data (16b), amount (4b), mode (2b)
//   req1_*     requester 1 operand: data (16b), amount (4b), mode (2b)
//   sh_in      operand to the shared shifter (0 outside SHIFT)
//   sh_val     shift amount to the shifter (0 outside SHIFT)
//   sh_mode    operation to the shifter: 00 SLL, 01 SRA, 1x ROR (0 outside SHIFT)
//   sh_out     shifter result, combinational in the same cycle
//   rsp_valid  per-requester result valid, one-hot or zero
//   rsp_ready  per-requester result accept; only the granted bit is honoured
//   rsp_data   result shared by both requesters, qualified by rsp_valid
//   busy       high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module shift_arbiter #(
    parameter int unsigned RR_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req0_data,
    input  logic [3:0]  req0_amt,
    input  logic [1:0]  req0_mode,
    input  logic [15:0] req1_data,
    input  logic [3:0]  req1_amt,
    input  logic [1:0]  req1_mode,

    output logic [15:0] sh_in,
    output logic [3:0]  sh_val,
    output logic [1:0]  sh_mode,
    input  logic [15:0] sh_out,

    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [15:0] rsp_data,

    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StResp  = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Registered operands and ownership of the transaction in flight.
    logic [15:0] op_data_q;
    logic [3:0]  op_amt_q;
    logic [1:0]  op_mode_q;
    logic        gnt_q;
    logic        last_grant_q;
    logic [15:0] rsp_data_q;

    logic        grant;
    logic        accept;
    logic        rsp_take;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    // On contention the round-robin winner is whoever did not win last time.
    // last_grant resets to 1 so requester 0 wins the first contention.
    always_comb begin
        grant = 1'b0;
        case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = (RR_EN != 0) ? ~last_grant_q : 1'b0;
            default: grant = 1'b0;
        endcase
    end

    assign accept   = (state_q == StIdle) && (req_valid != 2'b00);
    // Only the owner's rsp_ready bit can complete the response.
    assign rsp_take = (state_q == StResp) && rsp_ready[gnt_q];

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                state_d = StResp;
            end
            StResp: begin
                if (rsp_take) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        sh_in     = 16'h0000;
        sh_val    = 4'h0;
        sh_mode   = 2'b00;
        busy      = 1'b1;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (accept) begin
                    req_ready = grant ? 2'b10 : 2'b01;
                end
            end
            StShift: begin
                sh_in   = op_data_q;
                sh_val  = op_amt_q;
                sh_mode = op_mode_q;
            end
            StResp: begin
                rsp_valid = gnt_q ? 2'b10 : 2'b01;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign rsp_data = rsp_data_q;

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_data_q    <= 16'h0000;
            op_amt_q     <= 4'h0;
            op_mode_q    <= 2'b00;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (accept) begin
            op_data_q    <= grant ? req1_data : req0_data;
            op_amt_q     <= grant ? req1_amt  : req0_amt;
            op_mode_q    <= grant ? req1_mode : req0_mode;
            gnt_q        <= grant;
            last_grant_q <= grant;
        end
    end

    // Result is captured at the end of SHIFT and held until the next capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= 16'h0000;
        end else if (state_q == StShift) begin
            rsp_data_q <= sh_out;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter
//
// Runs a round-robin and a fixed-priority instance side by side on the same
// stimulus. Each instance gets its own behavioural shifter on sh_* / sh_out.
// Expected grants and results come from a transaction-level model: the
// arbitration rule applied to the request vector plus a remembered last
// winner, and a bit-by-bit shift function.
// -----------------------------------------------------------------------------
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  req_valid;
    logic [1:0]  rsp_ready;
    logic [15:0] req0_data, req1_data;
    logic [3:0]  req0_amt, req1_amt;
    logic [1:0]  req0_mode, req1_mode;

    // Index 0: RR_EN=1, index 1: RR_EN=0.
    logic [1:0]  req_ready [2];
    logic [1:0]  rsp_valid [2];
    logic [15:0] rsp_data  [2];
    logic [15:0] sh_in     [2];
    logic [15:0] sh_out    [2];
    logic [3:0]  sh_val    [2];
    logic [1:0]  sh_mode   [2];
    logic        busy      [2];

    int n_checks = 0;
    int n_fail   = 0;
    int lg [2];          // model of last winner per instance

    // Shift one bit position at a time so the model is plainly correct.
    function automatic logic [15:0] shift_ref(input logic [15:0] d, input logic [3:0] a,
                                              input logic [1:0] m);
        logic [15:0] r;
        r = d;
        for (int i = 0; i < int'(a); i++) begin
            if (m == 2'b00)      r = {r[14:0], 1'b0};
            else if (m == 2'b01) r = {r[15], r[15:1]};
            else                 r = {r[0], r[15:1]};
        end
        return r;
    endfunction

    assign sh_out[0] = shift_ref(sh_in[0], sh_val[0], sh_mode[0]);
    assign sh_out[1] = shift_ref(sh_in[1], sh_val[1], sh_mode[1]);

    shift_arbiter #(.RR_EN(1)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready[0]),
        .req0_data (req0_data),
        .req0_amt  (req0_amt),
        .req0_mode (req0_mode),
        .req1_data (req1_data),
        .req1_amt  (req1_amt),
        .req1_mode (req1_mode),
        .sh_in     (sh_in[0]),
        .sh_val    (sh_val[0]),
        .sh_mode   (sh_mode[0]),
        .sh_out    (sh_out[0]),
        .rsp_valid (rsp_valid[0]),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data[0]),
        .busy      (busy[0])
    );

    shift_arbiter #(.RR_EN(0)) u_fp (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready[1]),
        .req0_data (req0_data),
        .req0_amt  (req0_amt),
        .req0_mode (req0_mode),
        .req1_data (req1_data),
        .req1_amt  (req1_amt),
        .req1_mode (req1_mode),
        .sh_in     (sh_in[1]),
        .sh_val    (sh_val[1]),
        .sh_mode   (sh_mode[1]),
        .sh_out    (sh_out[1]),
        .rsp_valid (rsp_valid[1]),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data[1]),
        .busy      (busy[1])
    );

    // One full transaction. Entered and left just after a rising edge with
    // both instances in IDLE and req_valid low. When use_direct is set the
    // expected result is the given constant instead of the model.
    task automatic run_txn(input string name, input logic [1:0] valid,
                           input logic [15:0] d0, input logic [3:0] a0, input logic [1:0] m0,
                           input logic [15:0] d1, input logic [3:0] a1, input logic [1:0] m1,
                           input int hold, input bit use_direct, input logic [15:0] exp_direct);
        int          g   [2];
        logic [1:0]  oh  [2];
        logic [15:0] exp [2];
        logic [21:0] opd [2];
        req_valid = valid;
        req0_data = d0; req0_amt = a0; req0_mode = m0;
        req1_data = d1; req1_amt = a1; req1_mode = m1;
        rsp_ready = 2'b00;
        for (int k = 0; k < 2; k++) begin
            if (valid == 2'b01)      g[k] = 0;
            else if (valid == 2'b10) g[k] = 1;
            else                     g[k] = (k == 0) ? 1 - lg[k] : 0;
            oh[k]  = (g[k] == 1) ? 2'b10 : 2'b01;
            opd[k] = (g[k] == 1) ? {d1, a1, m1} : {d0, a0, m0};
            exp[k] = use_direct ? exp_direct
                   : ((g[k] == 1) ? shift_ref(d1, a1, m1) : shift_ref(d0, a0, m0));
        end
        // Cycle N: IDLE, winner sees req_ready.
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({req_ready[k], rsp_valid[k], busy[k], sh_in[k]} !== {oh[k], 2'b00, 1'b0, 16'h0}) begin
                n_fail++;
                $display("FAIL %s accept dut%0d: got %h want %h", name, k,
                         {req_ready[k], rsp_valid[k], busy[k], sh_in[k]},
                         {oh[k], 2'b00, 1'b0, 16'h0});
            end
        end
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) lg[k] = g[k];
        // Inputs wander after accept; the registered operands must not.
        req_valid = 2'($urandom_range(0, 3));
        req0_data = 16'($urandom); req1_data = 16'($urandom);
        req0_amt  = 4'($urandom);  req1_amt  = 4'($urandom);
        // Cycle N+1: SHIFT.
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({req_ready[k], rsp_valid[k], busy[k], sh_in[k], sh_val[k], sh_mode[k]} !==
                {2'b00, 2'b00, 1'b1, opd[k]}) begin
                n_fail++;
                $display("FAIL %s shift dut%0d: got %h want %h", name, k,
                         {req_ready[k], rsp_valid[k], busy[k], sh_in[k], sh_val[k], sh_mode[k]},
                         {2'b00, 2'b00, 1'b1, opd[k]});
            end
        end
        @(posedge clk); #1;
        // Cycle N+2 onward: RESP, held for 'hold' cycles then released.
        for (int h = 0; h <= hold; h++) begin
            if (h < hold) begin
                rsp_ready = (g[0] == g[1]) ? (~oh[0] & 2'($urandom_range(0, 3))) : 2'b00;
            end else begin
                rsp_ready = (g[0] == g[1]) ? (oh[0] | (~oh[0] & 2'($urandom_range(0, 3))))
                                           : 2'b11;
            end
            req_valid = 2'($urandom_range(0, 3));
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ({req_ready[k], rsp_valid[k], busy[k], sh_in[k], rsp_data[k]} !==
                    {2'b00, oh[k], 1'b1, 16'h0, exp[k]}) begin
                    n_fail++;
                    $display("FAIL %s resp%0d dut%0d: got %h want %h", name, h, k,
                             {req_ready[k], rsp_valid[k], busy[k], sh_in[k], rsp_data[k]},
                             {2'b00, oh[k], 1'b1, 16'h0, exp[k]});
                end
            end
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({req_ready[k], rsp_valid[k], busy[k], sh_in[k]} !== 21'h0) begin
                n_fail++;
                $display("FAIL %s idle dut%0d: got %h want %h", name, k,
                         {req_ready[k], rsp_valid[k], busy[k], sh_in[k]}, 21'h0);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({req_ready[k], rsp_valid[k], busy[k], sh_in[k], sh_val[k], sh_mode[k],
                 rsp_data[k]} !== 43'h0) begin
                n_fail++;
                $display("FAIL reset dut%0d: got %h want %h", k,
                         {req_ready[k], rsp_valid[k], busy[k], sh_in[k], sh_val[k],
                          sh_mode[k], rsp_data[k]}, 43'h0);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        lg[0] = 1;
        lg[1] = 1;
    endtask

    task automatic test_reset();
        req0_data = 16'hFFFF; req1_data = 16'hFFFF;
        req0_amt  = 4'hF;     req1_amt  = 4'hF;
        req0_mode = 2'b11;    req1_mode = 2'b11;
        apply_reset();
    endtask

    task automatic test_directed();
        run_txn("sra",  2'b01, 16'h8001, 4'd1, 2'b01, 16'h0000, 4'd0, 2'b00, 0, 1'b1, 16'hC000);
        run_txn("ror",  2'b10, 16'h0000, 4'd0, 2'b00, 16'h1234, 4'd4, 2'b10, 0, 1'b1, 16'h4123);
        run_txn("sll",  2'b01, 16'h00FF, 4'd8, 2'b00, 16'h0000, 4'd0, 2'b00, 3, 1'b1, 16'hFF00);
        run_txn("amt0", 2'b10, 16'h0000, 4'd0, 2'b00, 16'hA5A5, 4'd0, 2'b11, 3, 1'b1, 16'hA5A5);
    endtask

    task automatic test_contention();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            run_txn("contend", 2'b11, 16'($urandom), 4'($urandom), 2'($urandom),
                    16'($urandom), 4'($urandom), 2'($urandom), i % 2, 1'b0, 16'h0);
        end
    endtask

    task automatic test_random();
        logic [1:0] v;
        for (int i = 0; i < 24; i++) begin
            v = 2'($urandom_range(1, 3));
            run_txn("random", v, 16'($urandom), 4'($urandom), 2'($urandom),
                    16'($urandom), 4'($urandom), 2'($urandom), $urandom_range(0, 3),
                    1'b0, 16'h0);
        end
    endtask

    task automatic test_reset_in_shift();
        req_valid = 2'b01;
        req0_data = 16'h5A5A; req0_amt = 4'd3; req0_mode = 2'b00;
        @(posedge clk); #1;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ({rsp_valid[k], busy[k]} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL dropped dut%0d: got %h want %h", k,
                             {rsp_valid[k], busy[k]}, 3'b000);
                end
            end
        end
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        run_txn("post_rst", 2'b01, 16'h0F0F, 4'd4, 2'b10, 16'h0, 4'd0, 2'b00, 1, 1'b1, 16'hF0F0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        lg[0] = 1;
        lg[1] = 1;
        test_reset();
        test_directed();
        test_contention();
        test_random();
        test_reset_in_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
